// File: rtl/mips_dump_serializer_pkg.sv
// Shared definitions for the register/memory dump serializer: FSM states,
// section select codes and dump geometry.
package mips_dump_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_REGS = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_BOTH = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam int BYTES_PER_WORD    = 4;
  localparam int WORDS_PER_SECTION = 32;

endpackage

// File: rtl/mips_dump_serializer.sv
// Streams the register bank and/or data memory, MSB byte first per word,
// into the UART TX FIFO with one idle cycle after every write.
module mips_dump_serializer
  import mips_dump_serializer_pkg::*;
#(
  parameter int UART_BUS_SIZE          = 8,
  parameter int REGISTER_SIZE          = 32,
  parameter int REGISTER_BANK_BUS_SIZE = 1024,
  parameter int MEMORY_DATA_BUS_SIZE   = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [1:0]                        i_select,
  input  logic                              i_uart_full,
  input  logic [REGISTER_BANK_BUS_SIZE-1:0] i_registers_conntent,
  input  logic [MEMORY_DATA_BUS_SIZE-1:0]   i_memory_conntent,
  output logic                              o_uart_wr,
  output logic [UART_BUS_SIZE-1:0]          o_uart_data_wr,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int BASE_W = $clog2(REGISTER_BANK_BUS_SIZE);

  state_t     state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] byte_reg, byte_next;
  logic [4:0] word_reg, word_next;
  logic       section_reg, section_next;
  logic       final_reg, final_next;

  logic                     wr_next;
  logic [UART_BUS_SIZE-1:0] data_next;
  logic                     busy_next;
  logic                     done_next;

  logic [1:0]               byte_shift;
  logic [BASE_W-1:0]        bit_base;
  logic                     use_mem;
  logic [UART_BUS_SIZE-1:0] cur_byte;
  logic                     last_byte;
  logic                     last_word;
  logic                     last_section;

  // Byte 0 of a word is its most significant byte.
  assign byte_shift = 2'(2'd3 - byte_reg);
  assign bit_base   = BASE_W'(word_reg) * BASE_W'(REGISTER_SIZE)
                    + BASE_W'(byte_shift) * BASE_W'(UART_BUS_SIZE);
  assign use_mem    = (sel_reg == SEL_MEM) || section_reg;
  assign cur_byte   = use_mem ? i_memory_conntent[bit_base +: UART_BUS_SIZE]
                              : i_registers_conntent[bit_base +: UART_BUS_SIZE];

  assign last_byte    = (byte_reg == 2'(BYTES_PER_WORD - 1));
  assign last_word    = (word_reg == 5'(WORDS_PER_SECTION - 1));
  assign last_section = (sel_reg != SEL_BOTH) || section_reg;

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    byte_next    = byte_reg;
    word_next    = word_reg;
    section_next = section_reg;
    final_next   = final_reg;
    wr_next      = 1'b0;
    data_next    = o_uart_data_wr;

    case (state_reg)
      ST_IDLE: begin
        if (i_start && (i_select != SEL_RSVD)) begin
          sel_next     = i_select;
          byte_next    = 2'd0;
          word_next    = 5'd0;
          section_next = 1'b0;
          final_next   = 1'b0;
          state_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_uart_full) begin
          wr_next    = 1'b1;
          data_next  = cur_byte;
          byte_next  = byte_reg + 2'd1;
          final_next = last_byte && last_word && last_section;
          if (last_byte) begin
            word_next = word_reg + 5'd1;
            if (last_word && (sel_reg == SEL_BOTH)) begin
              section_next = ~section_reg;
            end
          end
          state_next = ST_GAP;
        end
      end
      // The idle cycle lets the FIFO full flag catch up with the write just made.
      ST_GAP:  state_next = final_reg ? ST_DONE : ST_SEND;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next == ST_SEND) || (state_next == ST_GAP);
    done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= 2'd0;
      byte_reg       <= 2'd0;
      word_reg       <= 5'd0;
      section_reg    <= 1'b0;
      final_reg      <= 1'b0;
      o_uart_wr      <= 1'b0;
      o_uart_data_wr <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      byte_reg       <= byte_next;
      word_reg       <= word_next;
      section_reg    <= section_next;
      final_reg      <= final_next;
      o_uart_wr      <= wr_next;
      o_uart_data_wr <= data_next;
      o_busy         <= busy_next;
      o_done         <= done_next;
    end
  end

endmodule

// File: tb/tb_mips_dump_serializer.sv
// Randomized self-checking bench: a cycle-numbered byte-queue model predicts
// every write, busy and done; directed scenarios pin literal byte values.
module tb_mips_dump_serializer;

  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic [1:0]    i_select = 2'b00;
  logic          i_uart_full = 1'b0;
  logic [1023:0] regs_bus = '0;
  logic [1023:0] mem_bus = '0;
  logic          o_uart_wr;
  logic [7:0]    o_uart_data_wr;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  mips_dump_serializer dut (
    .i_clk               (clk),
    .i_reset             (i_reset),
    .i_start             (i_start),
    .i_select            (i_select),
    .i_uart_full         (i_uart_full),
    .i_registers_conntent(regs_bus),
    .i_memory_conntent   (mem_bus),
    .o_uart_wr           (o_uart_wr),
    .o_uart_data_wr      (o_uart_data_wr),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state: the bytes still owed, and the cycle numbers that gate them.
  logic [7:0] exp_q[$];
  int  cyc = 0;
  bit  active = 1'b0;
  int  next_send = 0;
  int  done_edge = NEVER;

  // Observations of the DUT for the directed scenarios.
  logic [7:0] log_q[$];
  int  done_count = 0;
  int  first_wr_cyc = -1;
  int  done_cyc = -1;
  logic prev_wr = 1'b0;

  function automatic void build_expected(input logic [1:0] sel);
    exp_q.delete();
    for (int sec = 0; sec < 2; sec++) begin
      if ((sec == 0 && sel == 2'b01) || (sec == 1 && sel == 2'b00)) continue;
      for (int w = 0; w < 32; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (sec == 0) exp_q.push_back(regs_bus[w*32 + 24 - 8*b +: 8]);
          else          exp_q.push_back(mem_bus[w*32 + 24 - 8*b +: 8]);
        end
      end
    end
  endfunction

  logic       m_rst, m_start, m_full;
  logic [1:0] m_sel;
  logic       e_wr, e_busy, e_done;
  logic [7:0] e_byte;

  always @(posedge clk) begin
    m_rst   = i_reset;
    m_start = i_start;
    m_sel   = i_select;
    m_full  = i_uart_full;
    #1;
    cyc++;
    e_wr   = 1'b0;
    e_byte = 8'h00;
    if (m_rst) begin
      active = 1'b0;
      exp_q.delete();
      e_busy = 1'b0;
      e_done = 1'b0;
      chk("reset_data", o_uart_data_wr, 8'h00);
    end else begin
      if (!active) begin
        if (m_start && m_sel != 2'b11) begin
          build_expected(m_sel);
          active    = 1'b1;
          next_send = cyc + 1;
          done_edge = NEVER;
        end
      end else if (cyc == done_edge + 1) begin
        active = 1'b0;
      end else if (exp_q.size() > 0 && cyc >= next_send && !m_full) begin
        e_wr      = 1'b1;
        e_byte    = exp_q.pop_front();
        next_send = cyc + 2;
        if (exp_q.size() == 0) done_edge = cyc + 1;
      end
      e_done = active && (cyc == done_edge);
      e_busy = active && (cyc < done_edge);
    end
    chk("wr", o_uart_wr, e_wr);
    if (e_wr && o_uart_wr) chk("byte", o_uart_data_wr, e_byte);
    chk("busy", o_busy, e_busy);
    chk("done", o_done, e_done);
    chk("wr_spacing", o_uart_wr & prev_wr, 1'b0);
    if (o_uart_wr) begin
      if (log_q.size() == 0) first_wr_cyc = cyc;
      log_q.push_back(o_uart_data_wr);
    end
    if (o_done) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_wr = o_uart_wr;
  end

  task automatic clear_obs();
    log_q.delete();
    done_count   = 0;
    first_wr_cyc = -1;
    done_cyc     = -1;
  endtask

  task automatic pulse_start(input logic [1:0] s);
    @(negedge clk);
    i_select = s;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (done_count == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_seen"}, (done_count > 0), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_log(input string name, input int cnt, input int limit);
    int n = 0;
    while (log_q.size() < cnt && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached"}, (log_q.size() >= cnt), 1'b1);
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 32; k++) begin
      regs_bus[32*k +: 32] = {4{8'(k)}};
      mem_bus[32*k +: 32]  = $urandom;
    end
    regs_bus[63:32] = 32'h11223344;
  endtask

  task automatic load_random();
    for (int k = 0; k < 32; k++) begin
      regs_bus[32*k +: 32] = $urandom;
      mem_bus[32*k +: 32]  = $urandom;
    end
  endtask

  initial begin
    int hi;
    int n;
    logic [1:0] rs;

    repeat (3) @(negedge clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_wr", o_uart_wr, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_byte", o_uart_data_wr, 8'h00);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Register dump, no back-pressure.
    load_pattern();
    clear_obs();
    pulse_start(2'b00);
    wait_done("regs", 1000);
    chk("regs_count", log_q.size(), 128);
    chk("regs_b0", log_q[0], 8'h00);
    chk("regs_b4", log_q[4], 8'h11);
    chk("regs_b5", log_q[5], 8'h22);
    chk("regs_b6", log_q[6], 8'h33);
    chk("regs_b7", log_q[7], 8'h44);
    chk("regs_b127", log_q[127], 8'h1F);
    chk("regs_span", done_cyc - first_wr_cyc, 255);
    chk("regs_done_pulses", done_count, 1);

    // Both sections.
    load_random();
    mem_bus[1023:992] = 32'hDEADBEEF;
    clear_obs();
    pulse_start(2'b10);
    wait_done("both", 2000);
    chk("both_count", log_q.size(), 256);
    chk("both_sec2_first", log_q[128], mem_bus[31:24]);
    chk("both_b252", log_q[252], 8'hDE);
    chk("both_b253", log_q[253], 8'hAD);
    chk("both_b254", log_q[254], 8'hBE);
    chk("both_b255", log_q[255], 8'hEF);
    chk("both_span", done_cyc - first_wr_cyc, 511);
    chk("both_done_pulses", done_count, 1);

    // Back-pressure after the 5th byte.
    load_pattern();
    clear_obs();
    pulse_start(2'b00);
    wait_log("bp_five", 5, 100);
    i_uart_full = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_window_writes", log_q.size(), 5);
    i_uart_full = 1'b0;
    wait_done("bp", 1000);
    chk("bp_count", log_q.size(), 128);
    chk("bp_b5", log_q[5], 8'h22);

    // Start while busy is ignored.
    load_pattern();
    mem_bus[1023:992] = 32'hDEADBEEF;
    clear_obs();
    pulse_start(2'b00);
    wait_log("busy_fifty", 50, 200);
    pulse_start(2'b01);
    wait_done("busy", 1000);
    chk("busy_count", log_q.size(), 128);
    chk("busy_last", log_q[127], 8'h1F);
    chk("busy_done_pulses", done_count, 1);

    // Reset mid-dump, then a fresh memory dump.
    load_pattern();
    mem_bus[31:0] = 32'hA5B6C7D8;
    clear_obs();
    pulse_start(2'b00);
    wait_log("rst_seventy", 70, 300);
    i_reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_wr", o_uart_wr, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_byte", o_uart_data_wr, 8'h00);
    i_reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_more_writes", log_q.size(), 70);
    clear_obs();
    pulse_start(2'b01);
    wait_done("rst_mem", 1000);
    chk("rst_mem_count", log_q.size(), 128);
    chk("rst_mem_b0", log_q[0], 8'hA5);
    chk("rst_mem_b1", log_q[1], 8'hB6);

    // Reserved select does nothing.
    clear_obs();
    pulse_start(2'b11);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hi += int'(o_busy) + int'(o_uart_wr) + int'(o_done);
    end
    chk("rsvd_activity", hi, 0);

    // Random contents, selects and FIFO back-pressure.
    for (int t = 0; t < 4; t++) begin
      load_random();
      rs = 2'($urandom_range(0, 2));
      clear_obs();
      @(negedge clk);
      i_select = rs;
      i_start  = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
      n = 0;
      while (done_count == 0 && n < 3000) begin
        i_uart_full = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        n++;
      end
      i_uart_full = 1'b0;
      chk("rand_done_seen", (done_count > 0), 1'b1);
      chk("rand_count", log_q.size(), (rs == 2'b10) ? 256 : 128);
      repeat (3) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
